lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//   Load/store unit: initiator side of the word-wide data-memory port. Accepts one CPU
//   access at a time (lb/lbu/lw/sb/sw, plus lh/lhu/sh when enabled) and issues word-only
//   memory cycles. Byte stores are done here as read-modify-write. Big-endian lanes;
//   load results are sign- or zero-extended. Sits between the MEM stage and the 4 KiB data memory.
// PARAMETERS
//   ADDR_W   12   memory byte-address width; cpu_addr bits above ADDR_W-1 are ignored
// PORTS
//   clk         in   1   clock; all state updates on posedge
//   rst         in   1   synchronous, active-high reset
//   req         in   1   access request, sampled only when req_ready=1
//   req_we      in   1   1=store, 0=load
//   req_size    in   2   00=byte, 01=half, 10=word, 11=illegal
//   req_sign    in   1   loads: 1=sign-extend, 0=zero-extend
//   cpu_addr    in   32  byte address
//   cpu_wdata   in   32  store data; byte/half taken from LSBs
//   req_ready   out  1   1 only in IDLE
//   done        out  1   one-cycle completion pulse
//   rdata       out  32  extended load result, valid while done=1 for loads
//   misalign    out  1   valid with done; 1 = access faulted, no memory cycle issued
//   mem_addr    out  ADDR_W  byte address to memory, word-aligned (bits [1:0]=00)
//   mem_din     out  32  write word
//   mem_byteExt out  2   held at 2'b00 (word mode)
//   mem_wEn     out  2   2'b01 = write this posedge, 2'b00 otherwise
//   mem_dout    in   32  asynchronous read word for mem_addr
// BEHAVIOUR
//   States: IDLE, READ, WRITE. Outputs are decoded from state and registered fields.
//   Reset: state=IDLE, done=0, misalign=0, rdata=0, mem_wEn=00, mem_addr=0, mem_din=0.
//   IDLE: req_ready=1. On req, latch we/size/sign/addr/wdata. Then:
//     fault (size 11, half with addr[0]=1, word with addr[1:0]!=00) -> stay IDLE,
//       done=1 and misalign=1 next cycle, no memory access.
//     load or sub-word store -> READ. Word store -> WRITE.
//   READ (mem_wEn=00): sample mem_dout at the clock edge.
//     Load: extract lane, extend, register rdata, go to IDLE with done=1.
//     Store: merge into the sampled word, then go to WRITE.
//   WRITE: mem_wEn=01, mem_din=word. Go to IDLE with done=1, misalign=0.
//   Big-endian byte lane k=addr[1:0]: k=0 -> [31:24], k=1 -> [23:16], k=2 -> [15:8],
//     k=3 -> [7:0]. Half: addr[1]=0 -> [31:16], addr[1]=1 -> [15:0].
//   Latency (accept cycle = 0; done at cycle N): lw/lb/lh/sw N=2; sb/sh N=3; fault N=1.
//   done=1 coincides with IDLE, so back-to-back requests are accepted in the done cycle.
//   req while busy: ignored; the CPU holds req until accepted.
//   rdata holds its last value between loads. Stores leave rdata unchanged.
//   Reset mid-operation: IDLE at the reset edge. A pending WRITE is not performed;
//     done is not pulsed.
// CONFIGURATION
//   LSU_HALFWORD_EN defined: size 01 is legal (lh/lhu/sh), with half lanes as above.
//   Not defined: size 01 faults exactly like size 11.
// STRUCTURE
//   Package lsu_pkg: SIZE_B/SIZE_H/SIZE_W/SIZE_BAD codes, ST_IDLE/ST_READ/ST_WRITE
//     encodings, WEN_WRITE=2'b01, WEN_IDLE=2'b00.
//   Sub-module lsu_lane (combinational): lane extract + extend, and lane merge for stores.
//     The FSM and handshake stay in lsu_ctrl.
// TESTING
//   1 mem[0x100]=0x8844_2211; lb 0x101 sign=1 -> done at cycle 2, rdata=0x0000_0044;
//     lb 0x100 sign=1 -> 0xFFFF_FF88; lbu 0x100 -> 0x0000_0088.
//   2 sb 0x102 wdata=0x0000_00AB on mem 0x1122_3344 -> one READ then one WRITE (mem_wEn=01
//     exactly one cycle); mem=0x1122_AB44; done at cycle 3.
//   3 sw 0x204=0xDEAD_BEEF, then lw 0x204 issued in the done cycle -> accepted immediately,
//     rdata=0xDEAD_BEEF.
//   4 lw 0x102 and size=11 -> done+misalign at cycle 1, mem_wEn stays 00, memory unchanged.
//     With LSU_HALFWORD_EN undefined, lh 0x100 also faults.
//   5 With LSU_HALFWORD_EN: lh 0x102 on 0x1234_8001 -> 0xFFFF_8001; sh 0x100 0xBEEF -> 0xBEEF_8001.
//   6 Assert rst during the WRITE state of an sb -> memory unchanged, no done,
//     req_ready=1 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module  : lsu_pkg
//  Brief   : Shared size codes, FSM state encodings and memory write-enable
//            codes for the load/store unit.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_BAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [1:0] WEN_WRITE = 2'b01;
    localparam logic [1:0] WEN_IDLE  = 2'b00;

endpackage

`default_nettype wire

// File: rtl/lsu_lane.sv
// ============================================================================
//  Module  : lsu_lane
//  Brief   : Big-endian lane extract/extend for loads and lane merge for
//            sub-word stores (purely combinational).
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte        = 8'h00;
        w_half        = i_addr_lo[1] ? i_mem_word[15:0] : i_mem_word[31:16];
        o_load_data   = i_mem_word;
        o_merged_word = i_store_data;

        // Lane 0 is the most significant byte of the word.
        case (i_addr_lo)
            2'd0:    w_byte = i_mem_word[31:24];
            2'd1:    w_byte = i_mem_word[23:16];
            2'd2:    w_byte = i_mem_word[15:8];
            default: w_byte = i_mem_word[7:0];
        endcase

        case (i_size)
            SIZE_B: begin
                o_load_data   = {{24{i_sign & w_byte[7]}}, w_byte};
                o_merged_word = i_mem_word;
                case (i_addr_lo)
                    2'd0:    o_merged_word[31:24] = i_store_data[7:0];
                    2'd1:    o_merged_word[23:16] = i_store_data[7:0];
                    2'd2:    o_merged_word[15:8]  = i_store_data[7:0];
                    default: o_merged_word[7:0]   = i_store_data[7:0];
                endcase
            end
            SIZE_H: begin
                o_load_data   = {{16{i_sign & w_half[15]}}, w_half};
                o_merged_word = i_mem_word;
                if (i_addr_lo[1]) begin
                    o_merged_word[15:0]  = i_store_data[15:0];
                end else begin
                    o_merged_word[31:16] = i_store_data[15:0];
                end
            end
            default: begin
                o_load_data   = i_mem_word;
                o_merged_word = i_store_data;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
//  Module  : lsu_ctrl
//  Brief   : Load/store unit controller driving a word-only data memory port;
//            sub-word stores via read-modify-write. Halfword accesses are
//            legal only when LSU_HALFWORD_EN is defined.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              req_ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [1:0]        mem_byteExt,
    output logic [1:0]        mem_wEn,
    input  logic [31:0]       mem_dout
);

    state_t            r_state_q,    w_state_d;
    logic              r_we_q,       w_we_d;
    logic [1:0]        r_size_q,     w_size_d;
    logic              r_sign_q,     w_sign_d;
    logic [ADDR_W-1:0] r_addr_q,     w_addr_d;
    logic [31:0]       r_wdata_q,    w_wdata_d;
    logic [31:0]       r_word_q,     w_word_d;
    logic              r_done_q,     w_done_d;
    logic              r_misalign_q, w_misalign_d;
    logic [31:0]       r_rdata_q,    w_rdata_d;

    logic              w_fault;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged_word;
    logic              w_unused;

    assign w_unused = ^cpu_addr[31:ADDR_W];

    always_comb begin
        w_fault = (req_size == SIZE_BAD) ||
                  ((req_size == SIZE_W) && (cpu_addr[1:0] != 2'b00));
`ifdef LSU_HALFWORD_EN
        w_fault = w_fault || ((req_size == SIZE_H) && cpu_addr[0]);
`else
        w_fault = w_fault || (req_size == SIZE_H);
`endif
    end

    lsu_lane u_lane (
        .i_size        (r_size_q),
        .i_sign        (r_sign_q),
        .i_addr_lo     (r_addr_q[1:0]),
        .i_mem_word    (mem_dout),
        .i_store_data  (r_wdata_q),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_we_d       = r_we_q;
        w_size_d     = r_size_q;
        w_sign_d     = r_sign_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_word_d     = r_word_q;
        w_done_d     = 1'b0;
        w_misalign_d = 1'b0;
        w_rdata_d    = r_rdata_q;

        case (r_state_q)
            ST_IDLE: begin
                if (req) begin
                    w_we_d    = req_we;
                    w_size_d  = req_size;
                    w_sign_d  = req_sign;
                    w_addr_d  = cpu_addr[ADDR_W-1:0];
                    w_wdata_d = cpu_wdata;
                    if (w_fault) begin
                        w_done_d     = 1'b1;
                        w_misalign_d = 1'b1;
                    end else if (req_we && (req_size == SIZE_W)) begin
                        w_word_d  = cpu_wdata;
                        w_state_d = ST_WRITE;
                    end else begin
                        w_state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (r_we_q) begin
                    w_word_d  = w_merged_word;
                    w_state_d = ST_WRITE;
                end else begin
                    w_rdata_d = w_load_data;
                    w_done_d  = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_done_d  = 1'b1;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_we_q       <= 1'b0;
            r_size_q     <= SIZE_B;
            r_sign_q     <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_word_q     <= '0;
            r_done_q     <= 1'b0;
            r_misalign_q <= 1'b0;
            r_rdata_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_we_q       <= w_we_d;
            r_size_q     <= w_size_d;
            r_sign_q     <= w_sign_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_word_q     <= w_word_d;
            r_done_q     <= w_done_d;
            r_misalign_q <= w_misalign_d;
            r_rdata_q    <= w_rdata_d;
        end
    end

    // Reset gates the write strobe so an interrupted WRITE never reaches memory.
    assign mem_wEn     = ((r_state_q == ST_WRITE) && !rst) ? WEN_WRITE : WEN_IDLE;
    assign mem_addr    = {r_addr_q[ADDR_W-1:2], 2'b00};
    assign mem_din     = r_word_q;
    assign mem_byteExt = 2'b00;
    assign req_ready   = (r_state_q == ST_IDLE);
    assign done        = r_done_q;
    assign misalign    = r_misalign_q;
    assign rdata       = r_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
//  Module  : tb_lsu_ctrl
//  Brief   : Directed self-checking bench for lsu_ctrl with a word memory model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        req_ready;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_byteExt;
    logic [1:0]  mem_wEn;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:1023];

    int checks;
    int failures;

    lsu_ctrl #(.ADDR_W(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_sign    (req_sign),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .req_ready   (req_ready),
        .done        (done),
        .rdata       (rdata),
        .misalign    (misalign),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_byteExt (mem_byteExt),
        .mem_wEn     (mem_wEn),
        .mem_dout    (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_wEn == 2'b01) mem[mem_addr[11:2]] <= mem_din;
    end

    // One access: returns cycles to done (-1 on timeout), write strobes seen, misalign, ready at drive.
    task automatic access(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int cyc, output int wens, output logic mis, output logic rdy);
        @(negedge clk);
        req = 1'b1; req_we = we; req_size = size; req_sign = sign;
        cpu_addr = addr; cpu_wdata = wdata;
        rdy = req_ready;
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 1; wens = 0;
        while (!done && cyc < 20) begin
            if (mem_wEn == 2'b01) wens++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) cyc = -1;
        if (mem_wEn == 2'b01) wens++;
        mis = misalign;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        checks += 8;
        if (done !== 1'b0)        begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        if (misalign !== 1'b0)    begin failures++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
        if (rdata !== 32'h0)      begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        if (mem_wEn !== 2'b00)    begin failures++; $display("FAIL rst_wen got=%b exp=00", mem_wEn); end
        if (mem_addr !== 12'h0)   begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        if (mem_din !== 32'h0)    begin failures++; $display("FAIL rst_din got=%h exp=0", mem_din); end
        if (req_ready !== 1'b1)   begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        if (mem_byteExt !== 2'b00) begin failures++; $display("FAIL rst_byteext got=%b exp=00", mem_byteExt); end
    endtask

    task automatic test_byte_load();
        int c, w; logic m, r;
        access(1'b1, 2'b10, 1'b0, 32'h100, 32'h8844_2211, c, w, m, r);
        chk32("sw_pre_cycles", c, 2);
        chk32("sw_pre_mem", mem[32'h100 >> 2], 32'h8844_2211);
        access(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, c, w, m, r);
        chk32("lb101_cycles", c, 2);
        chk32("lb101_rdata", rdata, 32'h0000_0044);
        access(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, c, w, m, r);
        chk32("lb100_rdata", rdata, 32'hFFFF_FF88);
        access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, c, w, m, r);
        chk32("lbu100_rdata", rdata, 32'h0000_0088);
        chk32("lbu100_misalign", m, 0);
        access(1'b0, 2'b00, 1'b0, 32'hFFFF_F103, 32'h0, c, w, m, r);
        chk32("lbu_hiaddr_rdata", rdata, 32'h0000_0011);
    endtask

    task automatic test_byte_store();
        int c, w; logic m, r;
        access(1'b1, 2'b10, 1'b0, 32'h108, 32'h1122_3344, c, w, m, r);
        access(1'b1, 2'b00, 1'b0, 32'h10A, 32'h0000_00AB, c, w, m, r);
        chk32("sb_cycles", c, 3);
        chk32("sb_wen_count", w, 1);
        chk32("sb_mem", mem[32'h108 >> 2], 32'h1122_AB44);
        chk32("sb_rdata_kept", rdata, 32'h0000_0011);
        access(1'b1, 2'b00, 1'b0, 32'h10B, 32'h0000_0077, c, w, m, r);
        chk32("sb3_mem", mem[32'h108 >> 2], 32'h1122_AB77);
    endtask

    task automatic test_back_to_back();
        int c, w; logic m, r;
        access(1'b1, 2'b10, 1'b0, 32'h204, 32'hDEAD_BEEF, c, w, m, r);
        chk32("sw_cycles", c, 2);
        chk32("sw_wen_count", w, 1);
        access(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, c, w, m, r);
        chk32("b2b_ready", r, 1);
        chk32("b2b_cycles", c, 2);
        chk32("lw_rdata", rdata, 32'hDEAD_BEEF);
    endtask

    task automatic test_fault();
        int c, w; logic m, r;
        access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, c, w, m, r);
        chk32("lw_mis_cycles", c, 1);
        chk32("lw_mis_flag", m, 1);
        access(1'b1, 2'b11, 1'b0, 32'h204, 32'h1234_5678, c, w, m, r);
        chk32("bad_cycles", c, 1);
        chk32("bad_flag", m, 1);
        chk32("bad_wen", w, 0);
        chk32("bad_mem", mem[32'h204 >> 2], 32'hDEAD_BEEF);
        chk32("fault_rdata_kept", rdata, 32'hDEAD_BEEF);
`ifndef LSU_HALFWORD_EN
        access(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, c, w, m, r);
        chk32("lh_off_cycles", c, 1);
        chk32("lh_off_flag", m, 1);
`endif
    endtask

`ifdef LSU_HALFWORD_EN
    task automatic test_halfword();
        int c, w; logic m, r;
        access(1'b1, 2'b10, 1'b0, 32'h300, 32'h1234_8001, c, w, m, r);
        access(1'b0, 2'b01, 1'b1, 32'h302, 32'h0, c, w, m, r);
        chk32("lh_rdata", rdata, 32'hFFFF_8001);
        chk32("lh_cycles", c, 2);
        access(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, c, w, m, r);
        chk32("lhu_rdata", rdata, 32'h0000_8001);
        access(1'b1, 2'b01, 1'b0, 32'h300, 32'h0000_BEEF, c, w, m, r);
        chk32("sh_cycles", c, 3);
        chk32("sh_mem", mem[32'h300 >> 2], 32'hBEEF_8001);
        access(1'b0, 2'b01, 1'b0, 32'h301, 32'h0, c, w, m, r);
        chk32("lh_odd_flag", m, 1);
    endtask
`endif

    task automatic test_reset_mid_write();
        int c, w; logic m, r;
        access(1'b1, 2'b10, 1'b0, 32'h400, 32'h5566_7788, c, w, m, r);
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0;
        cpu_addr = 32'h400; cpu_wdata = 32'h0000_0011;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk32("mid_in_write", mem_wEn, 2'b01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk32("mid_mem", mem[32'h400 >> 2], 32'h5566_7788);
        chk32("mid_done", done, 0);
        chk32("mid_ready", req_ready, 1);
        @(posedge clk); #1;
        chk32("mid_done_later", done, 0);
        chk32("mid_mem_later", mem[32'h400 >> 2], 32'h5566_7788);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; req = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        test_reset();
        test_byte_load();
        test_byte_store();
        test_back_to_back();
        test_fault();
`ifdef LSU_HALFWORD_EN
        test_halfword();
`endif
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
